// File: rtl/score_7seg_scan_if.sv
// rtl/score_7seg_scan_if.sv - Score display bus between game core and 7-segment scan stage
interface score_7seg_scan_if;
   logic [13:0] bin;
   logic [6:0]  seg7out;
   logic [3:0]  seg7com;
   logic        busy;
   logic        ovf;

   modport master (output bin, input seg7out, seg7com, busy, ovf);
   modport slave  (input bin, output seg7out, seg7com, busy, ovf);
endinterface

// File: rtl/score_7seg_scan.sv
// rtl/score_7seg_scan.sv - Binary score to BCD conversion and multiplexed 7-segment scan
module score_7seg_scan #(
   parameter logic [15:0] SCAN_DIV = 16'd50000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input logic              clk,
   input logic              rst,
   score_7seg_scan_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t      state, state_nx;
   logic [13:0] last_bin, cap_bin, src;
   logic [15:0] bcd, bcd_adj, digits;
   logic [3:0]  cnt;
   logic        ovf_n, ovf_r, busy_c, start;
   logic [15:0] pcnt;
   logic [1:0]  dig_idx;
   logic [3:0]  nib;
   logic        blank;
   logic [6:0]  seg_r;
   logic [3:0]  com_r;

   // Double-dabble correction: every nibble of 5 or more gets +3 before the shift
   function automatic logic [15:0] add3(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++)
         if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
      return r;
   endfunction

   // Segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles cannot occur and stay dark
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   assign start   = (bus.bin != last_bin);
   assign bcd_adj = add3(bcd);

   // Conversion state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Conversion next-state: 14 shift iterations between detection and commit
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (cnt == 4'd13) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Conversion outputs: busy for every non-idle state
   always_comb begin
      busy_c = 1'b0;
      if (state != IDLE) busy_c = 1'b1;
   end

   // Conversion datapath: capture and saturate, shift-and-add, then commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_bin <= '0;
         cap_bin  <= '0;
         src      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         ovf_n    <= 1'b0;
         digits   <= '0;
         ovf_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cap_bin <= bus.bin;
               src     <= (bus.bin > 14'd9999) ? 14'd9999 : bus.bin;
               ovf_n   <= (bus.bin > 14'd9999);
               bcd     <= '0;
               cnt     <= '0;
            end
            SHIFT: begin
               bcd <= {bcd_adj[14:0], src[13]};
               src <= {src[12:0], 1'b0};
               cnt <= cnt + 4'd1;
            end
            COMMIT: begin
               digits   <= bcd;
               ovf_r    <= ovf_n;
               last_bin <= cap_bin;
            end
            default: ;
         endcase
      end
   end

   // Scan prescaler: advance the active digit every SCAN_DIV cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt    <= '0;
         dig_idx <= '0;
      end else if (pcnt == SCAN_DIV - 16'd1) begin
         pcnt    <= '0;
         dig_idx <= dig_idx + 2'd1;
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

   // Active nibble select and leading-zero blanking; interior zeros stay visible
   always_comb begin
      nib   = digits[3:0];
      blank = 1'b0;
      case (dig_idx)
         2'd0: nib = digits[3:0];
         2'd1: begin
            nib   = digits[7:4];
            blank = (digits[15:4] == 12'd0);
         end
         2'd2: begin
            nib   = digits[11:8];
            blank = (digits[15:8] == 8'd0);
         end
         2'd3: begin
            nib   = digits[15:12];
            blank = (digits[15:12] == 4'd0);
         end
         default: ;
      endcase
      if (!BLANK_LZ) blank = 1'b0;
   end

   // Segment and common drivers registered together so they switch on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_r <= 7'h3F;
         com_r <= 4'b0001;
      end else begin
         seg_r <= blank ? 7'h00 : seg_decode(nib);
         com_r <= 4'b0001 << dig_idx;
      end
   end

   assign bus.seg7out = seg_r;
   assign bus.seg7com = com_r;
   assign bus.busy    = busy_c;
   assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_score_7seg_scan.sv
// tb/tb_score_7seg_scan.sv - Self-checking bench for the score display stage
module tb_score_7seg_scan;
   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   last_raw = 0;
   logic [6:0] fr_seg [4];
   bit         fr_seen [4];
   logic [6:0] seg_tab [10];

   score_7seg_scan_if bus ();

   score_7seg_scan #(.SCAN_DIV(16'(DIV)), .BLANK_LZ(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected pattern for display position pos when the score is v
   function automatic logic [6:0] exp_seg(input int v, input int pos);
      int s, p10, d;
      s   = (v > 9999) ? 9999 : v;
      p10 = 1;
      for (int i = 0; i < pos; i++) p10 = p10 * 10;
      d = (s / p10) % 10;
      if (pos > 0 && s < p10) return 7'h00;
      return seg_tab[d];
   endfunction

   function automatic int com_pos(input logic [3:0] c);
      case (c)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic capture_frame();
      int p;
      for (int i = 0; i < 4; i++) fr_seen[i] = 1'b0;
      for (int k = 0; k < 4 * DIV; k++) begin
         @(negedge clk);
         p = com_pos(bus.seg7com);
         if (p >= 0) begin
            fr_seg[p]  = bus.seg7out;
            fr_seen[p] = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      logic [3:0] prev;
      int run, changes;
      rst = 1'b1;
      bus.bin = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (bus.seg7com !== 4'b0001) begin miscompares++; $display("FAIL reset_com: got %b expected 0001", bus.seg7com); end
      vectors++;
      if (bus.seg7out !== 7'h3F) begin miscompares++; $display("FAIL reset_seg: got %h expected 3f", bus.seg7out); end
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      vectors++;
      if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
      rst = 1'b0;
      prev = 4'b0001;
      run = 0;
      changes = 0;
      for (int k = 0; k < 6 * DIV; k++) begin
         @(negedge clk);
         if (bus.seg7com !== prev) begin
            vectors++;
            if (bus.seg7com !== {prev[2:0], prev[3]}) begin
               miscompares++;
               $display("FAIL scan_order: got %b expected %b", bus.seg7com, {prev[2:0], prev[3]});
            end
            if (changes > 0) begin
               vectors++;
               if (run !== DIV) begin miscompares++; $display("FAIL scan_dwell: got %0d expected %0d", run, DIV); end
            end
            changes++;
            run = 0;
            prev = bus.seg7com;
         end
         run++;
         vectors++;
         if (bus.seg7out !== ((bus.seg7com == 4'b0001) ? 7'h3F : 7'h00)) begin
            miscompares++;
            $display("FAIL zero_display: com %b got %h", bus.seg7com, bus.seg7out);
         end
         vectors++;
         if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL zero_no_conv: got busy %b expected 0", bus.busy); end
      end
      vectors++;
      if (changes < 4) begin miscompares++; $display("FAIL scan_changes: got %0d expected >=4", changes); end
   endtask

   task automatic test_convert(input int v);
      int nbusy, expb;
      expb = (v != last_raw) ? 15 : 0;
      bus.bin = 14'(v);
      nbusy = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) nbusy++;
      end
      vectors++;
      if (nbusy !== expb) begin miscompares++; $display("FAIL busy_len(%0d): got %0d expected %0d", v, nbusy, expb); end
      last_raw = v;
      vectors++;
      if (bus.ovf !== (v > 9999)) begin miscompares++; $display("FAIL ovf(%0d): got %b expected %b", v, bus.ovf, v > 9999); end
      capture_frame();
      for (int p = 0; p < 4; p++) begin
         vectors++;
         if (!fr_seen[p] || fr_seg[p] !== exp_seg(v, p)) begin
            miscompares++;
            $display("FAIL digit(%0d,pos%0d): got %h seen %0d expected %h", v, p, fr_seg[p], fr_seen[p], exp_seg(v, p));
         end
      end
   endtask

   task automatic test_latency();
      int p;
      bus.bin = 14'd1234;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         p = com_pos(bus.seg7com);
         if (k <= 15) begin
            vectors++;
            if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy_hi k=%0d: got %b expected 1", k, bus.busy); end
         end
         if (k == 16) begin
            vectors++;
            if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL lat_busy_lo: got %b expected 0", bus.busy); end
            vectors++;
            if (p < 0 || bus.seg7out !== exp_seg(0, p)) begin miscompares++; $display("FAIL lat_old_seg: got %h com %b", bus.seg7out, bus.seg7com); end
         end
         if (k == 17) begin
            vectors++;
            if (p < 0 || bus.seg7out !== exp_seg(1234, p)) begin miscompares++; $display("FAIL lat_new_seg: got %h com %b", bus.seg7out, bus.seg7com); end
         end
      end
      last_raw = 1234;
      test_convert(1234);
   endtask

   task automatic test_blank();
      test_convert(105);
   endtask

   task automatic test_ovf();
      test_convert(16383);
      test_convert(7);
   endtask

   task automatic test_change_during();
      int k, p, nbusy;
      bus.bin = 14'd1234;
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL chg_start: got %b expected 1", bus.busy); end
      repeat (5) @(negedge clk);
      bus.bin = 14'd42;
      k = 0;
      while (bus.busy === 1'b1 && k < 30) begin @(negedge clk); k++; end
      vectors++;
      if (k !== 10) begin miscompares++; $display("FAIL chg_first_pulse: got %0d more cycles expected 10", k); end
      @(negedge clk);
      p = com_pos(bus.seg7com);
      vectors++;
      if (p < 0 || bus.seg7out !== exp_seg(1234, p)) begin miscompares++; $display("FAIL chg_show_1234: got %h com %b", bus.seg7out, bus.seg7com); end
      nbusy = (bus.busy === 1'b1) ? 1 : 0;
      for (int j = 0; j < 19; j++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) nbusy++;
      end
      vectors++;
      if (nbusy !== 15) begin miscompares++; $display("FAIL chg_second_pulse: got %0d expected 15", nbusy); end
      last_raw = 42;
      test_convert(42);
   endtask

   task automatic test_abort();
      bus.bin = 14'd9876;
      repeat (5) @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_pre: got %b expected 1", bus.busy); end
      rst = 1'b1;
      #1;
      vectors++;
      if (bus.seg7com !== 4'b0001) begin miscompares++; $display("FAIL abort_com: got %b expected 0001", bus.seg7com); end
      vectors++;
      if (bus.seg7out !== 7'h3F) begin miscompares++; $display("FAIL abort_seg: got %h expected 3f", bus.seg7out); end
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
      vectors++;
      if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL abort_ovf: got %b expected 0", bus.ovf); end
      @(negedge clk);
      rst = 1'b0;
      last_raw = 0;
      test_convert(9876);
   endtask

   task automatic test_random();
      int bnd [10];
      int v;
      bnd = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};
      for (int i = 0; i < 14; i++) begin
         case ($urandom_range(0, 3))
            0:       v = bnd[$urandom_range(0, 9)];
            1:       v = last_raw;
            default: v = $urandom_range(0, 16383);
         endcase
         test_convert(v);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      bus.bin = '0;
      test_reset();
      test_latency();
      test_blank();
      test_ovf();
      test_change_during();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/score_7seg_scan.md
# score_7seg_scan

Score display stage for the pong game. It takes the 14-bit binary score counter from the game core and converts it to four BCD digits with a sequential double-dabble FSM. It then drives the 4-digit multiplexed 7-segment display by scanning digits, blanking leading zeros, and saturating values above 9999.

## Interface
- SCAN_DIV, default 16'd50000: CLK cycles each digit stays lit; legal range 2..65535.
- BLANK_LZ, default 1: 1 blanks leading zero digits; the ones digit is never blanked.
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- BIN  input  14  binary score from the game core; treated as quasi-static.
- SEG7OUT  output  7  segments {g,f,e,d,c,b,a}, 1 = segment lit.
- SEG7COM  output  4  one-hot digit enable, 1 = digit active; bit0 = ones, bit3 = thousands.
- BUSY  output  1  high while a conversion is in progress.
- OVF  output  1  high while the committed value came from BIN > 9999.

## Operation
- Conversion FSM has three states: IDLE, SHIFT, COMMIT.
- IDLE:
  - If BIN != last_bin, capture cap_bin <= BIN.
  - Capture src <= (BIN > 9999) ? 14'd9999 : BIN, and ovf_n <= (BIN > 9999).
  - Clear bcd (16 bit) to 0, set cnt <= 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Every bcd nibble >= 5 gets +3.
  - Then {bcd,src} shifts left by 1.
  - cnt increments; after the iteration with cnt == 13 (14 iterations total), go to COMMIT.
- COMMIT:
  - digits <= bcd, OVF <= ovf_n, last_bin <= cap_bin; return to IDLE.
- BIN changes while BUSY are ignored. On return to IDLE the new BIN mismatches last_bin and a fresh conversion starts the next cycle.
- BUSY = (state != IDLE).
- Scan prescaler: pcnt counts 0..SCAN_DIV-1 and wraps. On wrap, dig_idx (2 bit) increments 0→1→2→3→0.
- Segment decode, hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles A–F never occur; decode them to 00.
- Blanking (BLANK_LZ=1), where dN denotes digit N:
  - Digit 3 blank if d3==0.
  - Digit 2 blank if d3==0 && d2==0.
  - Digit 1 blank if d3, d2, d1 are all 0.
  - Digit 0 always shown.
  - Interior zeros are shown. Blank means SEG7OUT = 0.
- SEG7OUT and SEG7COM are both registered from the same dig_idx and digits values, so they switch on the same edge (no ghosting).

## Timing
- Reset values:
  - state = IDLE, last_bin = 0, cap_bin = 0, digits = 0, cnt = 0.
  - pcnt = 0, dig_idx = 0.
  - SEG7COM = 4'b0001, SEG7OUT = 7'b0111111, BUSY = 0, OVF = 0.
- Latency, with edge E0 being the IDLE edge that sees BIN != last_bin:
  - BUSY is high from E0+1 through E0+15.
  - SHIFT occupies edges E0+1..E0+14; COMMIT is at E0+15.
  - digits/OVF are new after E0+15.
  - SEG7OUT shows the new value on the active digit after E0+16 (output register).
  - Total: 16 cycles from detection to display.
- RST asserted mid-conversion aborts immediately to the reset values. After release, BIN != 0 triggers a new conversion on the first edge.
- BIN == 0 after reset causes no conversion; the display stays "   0".
- BIN > 9999 produces digits 9,9,9,9 with OVF=1. A later BIN <= 9999 clears OVF at its COMMIT.
- Each digit is held exactly SCAN_DIV cycles; one full frame = 4*SCAN_DIV cycles.
- Scanning is independent of the conversion FSM.

## Test plan
- Reset, SCAN_DIV=4, BIN=0:
  - Immediately: SEG7COM=0001, SEG7OUT=0111111, BUSY=0, OVF=0.
  - Over 16 cycles: COM walks 0001→0010→0100→1000, changing every 4 cycles; SEG7OUT=0000000 on COM 0010/0100/1000.
- BIN=1234:
  - BUSY high for exactly 15 cycles; digits committed 16 cycles after the change.
  - COM=0001→SEG 1100110; 0010→1001111; 0100→1011011; 1000→0000110.
- BIN=105:
  - COM=1000→0000000 (blank); 0100→0000110; 0010→0111111 (interior zero shown); 0001→1101101.
- BIN=14'd16383:
  - OVF=1; all four digits 1101111 (9).
  - Then BIN=7: OVF=0 after COMMIT; digits 3..1 blank, ones=0000111.
- Change during conversion: BIN=1234, then BIN=42 five cycles after BUSY rises.
  - Display shows 1234 first, then a second 15-cycle BUSY pulse, then display "  42".
- Abort: RST pulsed while BUSY during a 9876 conversion.
  - All outputs return to reset values immediately.
  - After release with BIN=9876: converts and displays 9876.
